// File: rtl/rp_mon_pkg.sv
// Shared types and default sizing for the RP LED monitor.
package rp_mon_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2,
        STALE = 2'd3
    } ch_state_t;

    localparam int unsigned DEF_CNT_W   = 32;
    localparam int unsigned DEF_TIMEOUT = 200_000_000;

endpackage

// File: rtl/rp_led_mon_ch.sv
// One monitored channel: measures the rise-to-rise period of an isolated LED and
// tracks whether the channel is still blinking.
module rp_led_mon_ch
    import rp_mon_pkg::*;
#(
    parameter int unsigned CNT_W   = DEF_CNT_W,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic             clk100,
    input  logic             rst,
    input  logic             rise,
    input  logic             decouple,
    output logic [CNT_W-1:0] period,
    output logic             period_vld,
    output logic             alive
);

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

    ch_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             vld_q, vld_d;
    logic             alive_q, alive_d;

    always_ff @(posedge clk100 or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            period_q <= '0;
            vld_q    <= 1'b0;
            alive_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            vld_q    <= vld_d;
            alive_q  <= alive_d;
        end
    end

    // A rise in the same cycle the counter hits TIMEOUT is checked first, so it wins.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        period_d = period_q;
        vld_d    = 1'b0;
        if (decouple) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    cnt_d = '0;
                    if (rise) begin
                        state_d = ARMED;
                        cnt_d   = ONE;
                    end
                end
                ARMED: begin
                    if (rise) begin
                        period_d = cnt_q;
                        vld_d    = 1'b1;
                        cnt_d    = ONE;
                        state_d  = RUN;
                    end else if (cnt_q == TIMEOUT_C) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + ONE;
                    end
                end
                RUN: begin
                    if (rise) begin
                        period_d = cnt_q;
                        vld_d    = 1'b1;
                        cnt_d    = ONE;
                    end else if (cnt_q == TIMEOUT_C) begin
                        state_d = STALE;
                    end else begin
                        cnt_d = cnt_q + ONE;
                    end
                end
                STALE: begin
                    if (rise) begin
                        state_d = ARMED;
                        cnt_d   = ONE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
        alive_d = (state_d == RUN);
    end

    assign period     = period_q;
    assign period_vld = vld_q;
    assign alive      = alive_q;

endmodule

// File: rtl/rp_led_mon.sv
// Static-side monitor for RP LED outputs: isolation during reconfiguration,
// per-channel blink period measurement and alive/stale status.
module rp_led_mon
    import rp_mon_pkg::*;
#(
    parameter int unsigned NUM_CH  = 2,
    parameter int unsigned CNT_W   = DEF_CNT_W,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT,
    parameter int unsigned ACK_DLY = 2
) (
    input  logic                    clk100,
    input  logic                    rst,
    input  logic                    decouple_i,
    input  logic [NUM_CH-1:0]       leds_i,
    output logic [NUM_CH-1:0]       leds_o,
    output logic [NUM_CH*CNT_W-1:0] period_o,
    output logic [NUM_CH-1:0]       period_vld_o,
    output logic [NUM_CH-1:0]       alive_o,
    output logic                    decouple_ack_o
);

    logic [NUM_CH-1:0]  led_q;
    logic [NUM_CH-1:0]  led_qq;
    logic [NUM_CH-1:0]  rise;
    logic [ACK_DLY-1:0] ack_sr;

    // Gating ahead of the first flop keeps RP glitches off the pins and out of the FSMs.
    always_ff @(posedge clk100 or posedge rst) begin
        if (rst) begin
            led_q  <= '0;
            led_qq <= '0;
        end else begin
            led_q  <= leds_i & ~{NUM_CH{decouple_i}};
            led_qq <= led_q;
        end
    end

    assign rise   = led_q & ~led_qq;
    assign leds_o = led_q;

    generate
        if (ACK_DLY == 1) begin : g_ack_one
            always_ff @(posedge clk100 or posedge rst) begin
                if (rst) ack_sr <= '0;
                else     ack_sr <= decouple_i;
            end
        end else begin : g_ack_multi
            always_ff @(posedge clk100 or posedge rst) begin
                if (rst) ack_sr <= '0;
                else     ack_sr <= {ack_sr[ACK_DLY-2:0], decouple_i};
            end
        end
    endgenerate

    assign decouple_ack_o = ack_sr[ACK_DLY-1];

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        rp_led_mon_ch #(
            .CNT_W   (CNT_W),
            .TIMEOUT (TIMEOUT)
        ) u_ch (
            .clk100     (clk100),
            .rst        (rst),
            .rise       (rise[i]),
            .decouple   (decouple_i),
            .period     (period_o[i*CNT_W +: CNT_W]),
            .period_vld (period_vld_o[i]),
            .alive      (alive_o[i])
        );
    end

endmodule

// File: tb/tb_rp_led_mon.sv
// Randomized bench for rp_led_mon against a timestamp-based reference model.
module tb_rp_led_mon;

    localparam int unsigned NUM_CH  = 2;
    localparam int unsigned CNT_W   = 16;
    localparam int unsigned TIMEOUT = 1000;
    localparam int unsigned ACK_DLY = 2;

    logic                    clk100 = 1'b0;
    logic                    rst = 1'b1;
    logic                    decouple_i = 1'b0;
    logic [NUM_CH-1:0]       leds_i = '0;
    logic [NUM_CH-1:0]       leds_o;
    logic [NUM_CH*CNT_W-1:0] period_o;
    logic [NUM_CH-1:0]       period_vld_o;
    logic [NUM_CH-1:0]       alive_o;
    logic                    decouple_ack_o;

    rp_led_mon #(
        .NUM_CH  (NUM_CH),
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT),
        .ACK_DLY (ACK_DLY)
    ) dut (
        .clk100         (clk100),
        .rst            (rst),
        .decouple_i     (decouple_i),
        .leds_i         (leds_i),
        .leds_o         (leds_o),
        .period_o       (period_o),
        .period_vld_o   (period_vld_o),
        .alive_o        (alive_o),
        .decouple_ack_o (decouple_ack_o)
    );

    always #5 clk100 = ~clk100;

    int checks   = 0;
    int failures = 0;
    bit run_chk  = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic logic [CNT_W-1:0] per_of(input int ch);
        return period_o[ch*CNT_W +: CNT_W];
    endfunction

    // ---------------- stimulus waveform generators ----------------
    // mode: 0 low, 1 periodic (per/hi), 2 random bits, 3 high
    int mode[NUM_CH] = '{default: 0};
    int per [NUM_CH] = '{default: 2};
    int hi  [NUM_CH] = '{default: 1};
    int ph  [NUM_CH] = '{default: 0};

    always @(posedge clk100) begin
        #1;
        for (int i = 0; i < NUM_CH; i++) begin
            case (mode[i])
                1: begin
                    leds_i[i] = (ph[i] < hi[i]);
                    ph[i] = (ph[i] + 1) % per[i];
                end
                2:       leds_i[i] = 1'($urandom_range(0, 1));
                3:       leds_i[i] = 1'b1;
                default: leds_i[i] = 1'b0;
            endcase
        end
    end

    task automatic set_sq(input int ch, input int p, input int h);
        mode[ch] = 1;
        per[ch]  = p;
        hi[ch]   = h;
        ph[ch]   = 0;
    endtask

    // ---------------- reference model ----------------
    // Each channel remembers the cycle of its last rise; a later rise within
    // TIMEOUT cycles of it is a measurement, anything else merely re-arms.
    int                unsigned cyc = 0;
    int                unsigned m_ref[NUM_CH] = '{default: 0};
    bit                m_have[NUM_CH] = '{default: 1'b0};
    logic [NUM_CH-1:0] m_lq = '0, m_lqq = '0, m_vld = '0, m_alive = '0;
    logic [CNT_W-1:0]  m_per[NUM_CH] = '{default: '0};
    logic [ACK_DLY-1:0] m_hist = '0;

    always @(posedge clk100 or posedge rst) begin
        if (rst) begin
            m_lq = '0; m_lqq = '0; m_vld = '0; m_alive = '0; m_hist = '0;
            for (int i = 0; i < NUM_CH; i++) begin
                m_have[i] = 1'b0;
                m_per[i]  = '0;
            end
        end else begin
            cyc++;
            for (int i = 0; i < NUM_CH; i++) begin
                m_vld[i] = 1'b0;
                if (decouple_i) begin
                    m_have[i]  = 1'b0;
                    m_alive[i] = 1'b0;
                end else if (m_lq[i] && !m_lqq[i]) begin
                    if (m_have[i] && (cyc - m_ref[i]) <= TIMEOUT) begin
                        m_per[i]   = CNT_W'(cyc - m_ref[i]);
                        m_vld[i]   = 1'b1;
                        m_alive[i] = 1'b1;
                    end else begin
                        m_alive[i] = 1'b0;
                    end
                    m_ref[i]  = cyc;
                    m_have[i] = 1'b1;
                end else if (m_have[i] && (cyc - m_ref[i]) == TIMEOUT) begin
                    m_alive[i] = 1'b0;
                end
            end
            m_lqq = m_lq;
            m_lq  = leds_i & ~{NUM_CH{decouple_i}};
            for (int j = ACK_DLY - 1; j > 0; j--) m_hist[j] = m_hist[j-1];
            m_hist[0] = decouple_i;
        end
    end

    always @(negedge clk100) begin
        if (run_chk) begin
            chk("leds_o", 64'(leds_o), 64'(m_lq));
            chk("period_vld_o", 64'(period_vld_o), 64'(m_vld));
            chk("alive_o", 64'(alive_o), 64'(m_alive));
            chk("decouple_ack_o", 64'(decouple_ack_o), 64'(m_hist[ACK_DLY-1]));
            for (int i = 0; i < NUM_CH; i++) chk("period_o", 64'(per_of(i)), 64'(m_per[i]));
        end
    end

    // ---------------- directed + random sequence ----------------
    int n;
    int vcount;
    int p;

    initial begin
        repeat (3) @(negedge clk100);
        run_chk = 1'b1;
        rst = 1'b0;

        // Reset mid-operation
        set_sq(0, 100, 50);
        set_sq(1, 250, 125);
        repeat (400) @(negedge clk100);
        @(posedge clk100);
        #2 rst = 1'b1;
        #1;
        chk("rst_leds_o", 64'(leds_o), 64'd0);
        chk("rst_period_o", 64'(period_o), 64'd0);
        chk("rst_alive_o", 64'(alive_o), 64'd0);
        chk("rst_vld", 64'(period_vld_o), 64'd0);
        repeat (3) @(negedge clk100);
        rst = 1'b0;

        // Period measurement
        repeat (700) @(negedge clk100);
        chk("period_ch0", 64'(per_of(0)), 64'd100);
        chk("period_ch1", 64'(per_of(1)), 64'd250);
        chk("alive_both", 64'(alive_o), 64'd3);

        // Timeout on ch0
        n = 0;
        while (!period_vld_o[0] && n < 200) begin
            @(negedge clk100);
            n++;
        end
        chk("vld_ch0_seen", 64'(period_vld_o[0]), 64'd1);
        mode[0] = 0;
        n = 0;
        do begin
            @(negedge clk100);
            n++;
        end while (alive_o[0] && n < 2000);
        chk("timeout_cycles", 64'(n), 64'd1000);
        chk("timeout_period_hold", 64'(per_of(0)), 64'd100);
        chk("timeout_ch1_alive", 64'(alive_o[1]), 64'd1);
        set_sq(0, 100, 50);
        repeat (60) @(negedge clk100);
        chk("resume_armed_only", 64'(alive_o[0]), 64'd0);
        repeat (90) @(negedge clk100);
        chk("resume_alive", 64'(alive_o[0]), 64'd1);
        chk("resume_period", 64'(per_of(0)), 64'd100);

        // Decouple with random toggling
        decouple_i = 1'b1;
        @(negedge clk100);
        mode[0] = 2;
        mode[1] = 2;
        chk("dec_leds_off", 64'(leds_o), 64'd0);
        vcount = 0;
        repeat (30) begin
            @(negedge clk100);
            vcount += $countones(period_vld_o);
        end
        chk("dec_no_vld", 64'(vcount), 64'd0);
        chk("dec_ack", 64'(decouple_ack_o), 64'd1);
        chk("dec_alive", 64'(alive_o), 64'd0);
        chk("dec_period_hold0", 64'(per_of(0)), 64'd100);
        chk("dec_period_hold1", 64'(per_of(1)), 64'd250);
        decouple_i = 1'b0;
        set_sq(0, 100, 50);
        set_sq(1, 250, 125);
        repeat (3) @(negedge clk100);
        chk("dec_ack_fall", 64'(decouple_ack_o), 64'd0);
        repeat (600) @(negedge clk100);

        // Boundaries: rise exactly at TIMEOUT, period 3, rise under decouple
        set_sq(0, 1000, 1);
        repeat (2300) @(negedge clk100);
        chk("period_at_timeout", 64'(per_of(0)), 64'd1000);
        chk("alive_at_timeout", 64'(alive_o[0]), 64'd1);
        set_sq(0, 3, 1);
        repeat (30) @(negedge clk100);
        chk("period_3", 64'(per_of(0)), 64'd3);
        mode[0] = 0;
        repeat (5) @(negedge clk100);
        set_sq(0, 50, 25);
        @(negedge clk100);
        @(negedge clk100);
        decouple_i = 1'b1;
        vcount = 0;
        repeat (10) begin
            @(negedge clk100);
            vcount += int'(period_vld_o[0]);
        end
        chk("rise_vs_decouple", 64'(vcount), 64'd0);
        decouple_i = 1'b0;
        repeat (200) @(negedge clk100);

        // Randomized traffic, checked cycle by cycle against the model
        for (int r = 0; r < 10; r++) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if ($urandom_range(0, 4) == 0) begin
                    mode[i] = 2;
                end else begin
                    p = $urandom_range(2, 1300);
                    set_sq(i, p, $urandom_range(1, p - 1));
                end
            end
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 200)) @(negedge clk100);
                decouple_i = 1'b1;
                repeat ($urandom_range(1, 40)) @(negedge clk100);
                decouple_i = 1'b0;
            end
            repeat ($urandom_range(300, 1500)) @(negedge clk100);
        end

        run_chk = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
